// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and constants for the two-port CPU memory bus arbiter.
// Grant state encoding and port indices are used by the arbiter and its bench.
package cpu_bus_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_A = 2'd1,
    ARB_GRANT_B = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_A = 1'b0;
  localparam logic ARB_PORT_B = 1'b1;

  function automatic arb_state_e grant_state(input logic port);
    return (port == ARB_PORT_B) ? ARB_GRANT_B : ARB_GRANT_A;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Level-request / one-cycle-ready bus used both by the requesters and the shared bus.
// The master drives request/rw/address/wdata, the slave answers with ready/rdata.
interface cpu_bus_arbiter_if;
  import cpu_bus_arbiter_pkg::*;

  logic              request;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output request, rw, address, wdata,
    input  ready, rdata
  );

  modport slave (
    input  request, rw, address, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the single CPU memory bus between instruction fill (A) and data (B).
// Build option CPU_BUS_ARBITER_ROUND_ROBIN_EN swaps the B-priority/streak guard for round robin.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_B_STREAK = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  cpu_bus_arbiter_if.slave  pa,
  cpu_bus_arbiter_if.slave  pb,
  cpu_bus_arbiter_if.master bus,
  output logic              o_busy
);

  arb_state_e state_q, state_d;
  logic       a_pend, b_pend, pick_b;
  logic       arbitrate;

  // Port A is read-only; its direction and write data are never forwarded.
  logic unused_pa;
  assign unused_pa = ^{pa.rw, pa.wdata};

  assign a_pend    = pa.request;
  assign b_pend    = pb.request;
  assign arbitrate = (state_q == ARB_IDLE) && (a_pend || b_pend);

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    pick_b = b_pend;
    if (a_pend && b_pend) begin
      pick_b = (last_q == ARB_PORT_A);
    end
  end

  always_comb begin
    last_d = last_q;
    if (arbitrate) begin
      last_d = pick_b ? ARB_PORT_B : ARB_PORT_A;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_q <= ARB_PORT_A;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_B_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  always_comb begin
    pick_b = b_pend;
    if (a_pend && b_pend) begin
      pick_b = (streak_q != MAX_STREAK);
    end
  end

  // Counts B wins that left A waiting; any other arbitration outcome clears it.
  always_comb begin
    streak_d = streak_q;
    if (arbitrate) begin
      if (pick_b && a_pend) begin
        streak_d = (streak_q == MAX_STREAK) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant ends on the bus ready or when its requester abandons the request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (arbitrate) begin
          state_d = grant_state(pick_b ? ARB_PORT_B : ARB_PORT_A);
        end
      end
      ARB_GRANT_A: begin
        if (!pa.request || bus.ready) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT_B: begin
        if (!pb.request || bus.ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so a reset aborts the bus cycle at once.
  always_comb begin
    bus.request = 1'b0;
    bus.rw      = 1'b0;
    bus.address = '0;
    bus.wdata   = '0;
    pa.ready    = 1'b0;
    pa.rdata    = '0;
    pb.ready    = 1'b0;
    pb.rdata    = '0;
    o_busy      = 1'b0;
    if (!i_reset) begin
      case (state_q)
        ARB_GRANT_A: begin
          bus.request = pa.request;
          bus.address = pa.address;
          o_busy      = 1'b1;
          if (pa.request && bus.ready) begin
            pa.ready = 1'b1;
            pa.rdata = bus.rdata;
          end
        end
        ARB_GRANT_B: begin
          bus.request = pb.request;
          bus.rw      = pb.rw;
          bus.address = pb.address;
          bus.wdata   = pb.wdata;
          o_busy      = 1'b1;
          if (pb.request && bus.ready) begin
            pb.ready = 1'b1;
            pb.rdata = bus.rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_cpu_bus_arbiter;

  localparam int MAX_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic auto_ack;
  logic man_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter_if pa_if ();
  cpu_bus_arbiter_if pb_if ();
  cpu_bus_arbiter_if bus_if ();

  always_comb bus_if.ready = auto_ack ? bus_if.request : man_ready;

  cpu_bus_arbiter #(.MAX_B_STREAK(MAX_B)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .pa     (pa_if),
    .pb     (pb_if),
    .bus    (bus_if),
    .o_busy (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pa_if.request = 1'b0; pa_if.rw = 1'b0; pa_if.address = '0; pa_if.wdata = '0;
    pb_if.request = 1'b0; pb_if.rw = 1'b0; pb_if.address = '0; pb_if.wdata = '0;
    bus_if.rdata  = '0;
    man_ready     = 1'b0;
    auto_ack      = 1'b0;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    pa_if.request = 1'b1; pa_if.address = 32'h0000_0100;
    pb_if.request = 1'b1; pb_if.address = 32'h0000_0200;
    pb_if.rw = 1'b1; pb_if.wdata = 32'h1234_5678;
    man_ready = 1'b1; bus_if.rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({bus_if.request, bus_if.rw, busy, pa_if.ready, pb_if.ready} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl cycle=%0d got req/rw/busy/ra/rb=%b required=00000", c,
                 {bus_if.request, bus_if.rw, busy, pa_if.ready, pb_if.ready});
      end
      checks++;
      if ({bus_if.address, bus_if.wdata, pa_if.rdata, pb_if.rdata} !== 128'h0) begin
        failures++;
        $display("FAIL reset_data cycle=%0d got addr=%h wdata=%h ra=%h rb=%h required all 0", c,
                 bus_if.address, bus_if.wdata, pa_if.rdata, pb_if.rdata);
      end
      step();
    end
    rst = 1'b0;
    man_ready = 1'b0;
    #1;
    checks++;
    if (bus_if.request !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got bus_request=%b required=0", bus_if.request);
    end
    step();
    #1;
    checks++;
    if ({bus_if.request, busy, bus_if.address} !== {2'b11, 32'h0000_0200}) begin
      failures++;
      $display("FAIL reset_first_grant_b got req=%b busy=%b addr=%h required req=1 busy=1 addr=00000200",
               bus_if.request, busy, bus_if.address);
    end
    do_reset();
  endtask

  task automatic test_single_a();
    pa_if.request = 1'b1;
    pa_if.address = 32'h0000_1000;
    #1;
    checks++;
    if (bus_if.request !== 1'b0) begin
      failures++;
      $display("FAIL single_a_latency got bus_request=%b required=0", bus_if.request);
    end
    step();
    checks++;
    if ({bus_if.request, bus_if.rw, busy, bus_if.address} !== {3'b101, 32'h0000_1000}) begin
      failures++;
      $display("FAIL single_a_grant got req=%b rw=%b busy=%b addr=%h required 1 0 1 00001000",
               bus_if.request, bus_if.rw, busy, bus_if.address);
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({pa_if.ready, pb_if.ready, bus_if.request} !== 3'b001) begin
        failures++;
        $display("FAIL single_a_wait w=%0d got ra=%b rb=%b req=%b required 0 0 1", w,
                 pa_if.ready, pb_if.ready, bus_if.request);
      end
      step();
    end
    man_ready = 1'b1;
    bus_if.rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({pa_if.ready, pa_if.rdata, pb_if.ready, pb_if.rdata} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL single_a_ready got ra=%b rdata=%h rb=%b rbdata=%h required 1 deadbeef 0 0",
               pa_if.ready, pa_if.rdata, pb_if.ready, pb_if.rdata);
    end
    step();
    man_ready = 1'b0;
    pa_if.request = 1'b0;
    #1;
    checks++;
    if ({pa_if.ready, bus_if.request, busy} !== 3'b000) begin
      failures++;
      $display("FAIL single_a_after got ra=%b req=%b busy=%b required 0 0 0",
               pa_if.ready, bus_if.request, busy);
    end
  endtask

  task automatic test_b_write();
    do_reset();
    pb_if.request = 1'b1; pb_if.rw = 1'b1;
    pb_if.address = 32'h2000_0004; pb_if.wdata = 32'hCAFE_F00D;
    step();
    for (int w = 0; w < 3; w++) begin
      if (w == 2) begin
        man_ready = 1'b1;
        bus_if.rdata = 32'h0BAD_0BAD;
        #1;
      end
      checks++;
      if ({bus_if.request, bus_if.rw, bus_if.address, bus_if.wdata, pb_if.ready}
          !== {2'b11, 32'h2000_0004, 32'hCAFE_F00D, (w == 2)}) begin
        failures++;
        $display("FAIL b_write_grant w=%0d got req=%b rw=%b addr=%h wdata=%h rb=%b required 1 1 20000004 cafef00d %0d",
                 w, bus_if.request, bus_if.rw, bus_if.address, bus_if.wdata, pb_if.ready, (w == 2));
      end
      step();
    end
    man_ready = 1'b0;
    pb_if.rw = 1'b0;
    pb_if.address = 32'h2000_0008;
    #1;
    checks++;
    if ({bus_if.request, busy, pb_if.ready} !== 3'b000) begin
      failures++;
      $display("FAIL b_back_to_back_idle got req=%b busy=%b rb=%b required 0 0 0",
               bus_if.request, busy, pb_if.ready);
    end
    step();
    checks++;
    if ({bus_if.request, bus_if.rw, bus_if.address} !== {2'b10, 32'h2000_0008}) begin
      failures++;
      $display("FAIL b_back_to_back_grant got req=%b rw=%b addr=%h required 1 0 20000008",
               bus_if.request, bus_if.rw, bus_if.address);
    end
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    pb_if.request = 1'b0;
  endtask

  task automatic test_starvation();
    int got[$];
    int exp_port;
    int streak;
    do_reset();
    pa_if.request = 1'b1; pa_if.address = 32'hA000_0000;
    pb_if.request = 1'b1; pb_if.address = 32'hB000_0000;
    auto_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus_if.request === 1'b1) begin
        got.push_back((bus_if.address == 32'hA000_0000) ? 0 : 1);
      end
    end
    auto_ack = 1'b0;
    pa_if.request = 1'b0;
    pb_if.request = 1'b0;
    checks++;
    if (got.size() < 12) begin
      failures++;
      $display("FAIL starve_grant_count got=%0d required>=12", got.size());
    end
    streak = 0;
    for (int k = 0; k < 12 && k < got.size(); k++) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      exp_port = (k % 2 == 0) ? 1 : 0;
`else
      if (streak == MAX_B) begin
        exp_port = 0;
        streak = 0;
      end else begin
        exp_port = 1;
        streak++;
      end
`endif
      checks++;
      if (got[k] !== exp_port) begin
        failures++;
        $display("FAIL starve_order grant=%0d got port=%0d required port=%0d", k, got[k], exp_port);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    pb_if.request = 1'b1; pb_if.address = 32'h3000_0000;
    step();
    checks++;
    if (bus_if.request !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_grant got req=%b required=1", bus_if.request);
    end
    #2;
    rst = 1'b1;
    man_ready = 1'b1;
    #1;
    checks++;
    if ({bus_if.request, pb_if.ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_drop got req=%b rb=%b busy=%b required 0 0 0",
               bus_if.request, pb_if.ready, busy);
    end
    step();
    rst = 1'b0;
    pb_if.request = 1'b0;
    #1;
    checks++;
    if ({pb_if.ready, bus_if.request} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_late_ready got rb=%b req=%b required 0 0", pb_if.ready, bus_if.request);
    end
    step();
    man_ready = 1'b0;
  endtask

  task automatic test_stray_ready();
    do_reset();
    step();
    man_ready = 1'b1;
    bus_if.rdata = 32'h5555_AAAA;
    #1;
    checks++;
    if ({pa_if.ready, pb_if.ready, busy, pa_if.rdata, pb_if.rdata} !== 67'h0) begin
      failures++;
      $display("FAIL stray_ready got ra=%b rb=%b busy=%b required 0 0 0",
               pa_if.ready, pb_if.ready, busy);
    end
    step();
    man_ready = 1'b0;
    pa_if.request = 1'b1;
    pa_if.address = 32'h0000_4000;
    #1;
    checks++;
    if ({bus_if.request, busy} !== 2'b00) begin
      failures++;
      $display("FAIL stray_state got req=%b busy=%b required 0 0", bus_if.request, busy);
    end
    step();
    checks++;
    if ({bus_if.request, bus_if.address} !== {1'b1, 32'h0000_4000}) begin
      failures++;
      $display("FAIL stray_then_grant got req=%b addr=%h required 1 00004000",
               bus_if.request, bus_if.address);
    end
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    pa_if.request = 1'b0;
  endtask

  task automatic test_random();
    int owner, streak, last, wait_cnt;
    logic a_req, b_req, b_rw, rdy, a_done, b_done;
    logic [31:0] a_addr, b_addr, b_wdata, rdat;
    logic exp_req, exp_rw, exp_busy, exp_ra, exp_rb;
    logic [31:0] exp_addr, exp_wdata, exp_rda, exp_rdb;
    int winner;
    do_reset();
    owner = 0; streak = 0; last = 0; wait_cnt = 0;
    a_req = 0; b_req = 0; b_rw = 0; a_done = 0; b_done = 0;
    a_addr = '0; b_addr = '0; b_wdata = '0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (a_done || !a_req) begin
        a_req = ($urandom % 3 != 0);
        a_addr = $urandom;
      end
      if (b_done || !b_req) begin
        b_req = ($urandom % 3 != 0);
        b_addr = $urandom; b_wdata = $urandom; b_rw = $urandom % 2;
      end
      rdy  = (owner != 0) ? (wait_cnt == 0) : ($urandom % 8 == 0);
      rdat = $urandom;
      pa_if.request = a_req; pa_if.address = a_addr;
      pb_if.request = b_req; pb_if.address = b_addr;
      pb_if.rw = b_rw; pb_if.wdata = b_wdata;
      man_ready = rdy; bus_if.rdata = rdat;
      #1;
      exp_req   = (owner == 1) ? a_req : (owner == 2) ? b_req : 1'b0;
      exp_rw    = (owner == 2) ? b_rw : 1'b0;
      exp_busy  = (owner != 0);
      exp_addr  = (owner == 1) ? a_addr : (owner == 2) ? b_addr : 32'h0;
      exp_wdata = (owner == 2) ? b_wdata : 32'h0;
      exp_ra    = (owner == 1) && a_req && rdy;
      exp_rb    = (owner == 2) && b_req && rdy;
      exp_rda   = exp_ra ? rdat : 32'h0;
      exp_rdb   = exp_rb ? rdat : 32'h0;
      checks++;
      if ({bus_if.request, bus_if.rw, busy, pa_if.ready, pb_if.ready}
          !== {exp_req, exp_rw, exp_busy, exp_ra, exp_rb}) begin
        failures++;
        $display("FAIL rand_ctrl cycle=%0d got req/rw/busy/ra/rb=%b required %b", c,
                 {bus_if.request, bus_if.rw, busy, pa_if.ready, pb_if.ready},
                 {exp_req, exp_rw, exp_busy, exp_ra, exp_rb});
      end
      checks++;
      if ({bus_if.address, bus_if.wdata} !== {exp_addr, exp_wdata}) begin
        failures++;
        $display("FAIL rand_bus cycle=%0d got addr=%h wdata=%h required addr=%h wdata=%h", c,
                 bus_if.address, bus_if.wdata, exp_addr, exp_wdata);
      end
      checks++;
      if ({pa_if.rdata, pb_if.rdata} !== {exp_rda, exp_rdb}) begin
        failures++;
        $display("FAIL rand_rdata cycle=%0d got a=%h b=%h required a=%h b=%h", c,
                 pa_if.rdata, pb_if.rdata, exp_rda, exp_rdb);
      end
      a_done = exp_ra;
      b_done = exp_rb;
      if (owner == 0) begin
        if (a_req || b_req) begin
          if (a_req && b_req) begin
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
            winner = (last == 0) ? 2 : 1;
`else
            winner = (streak == MAX_B) ? 1 : 2;
`endif
          end else begin
            winner = a_req ? 1 : 2;
          end
          if (winner == 2 && a_req) streak = (streak < MAX_B) ? streak + 1 : MAX_B;
          else streak = 0;
          last = (winner == 2) ? 1 : 0;
          owner = winner;
          wait_cnt = $urandom_range(0, 3);
        end
      end else if (((owner == 1) ? !a_req : !b_req) || rdy) begin
        owner = 0;
      end else begin
        wait_cnt--;
      end
    end
    step();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_a();
    test_b_write();
    test_starvation();
    test_reset_mid_grant();
    test_stray_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
